// File: rtl/bmc_soft_pipe_if.sv
// Branch-in / metrics-out handshake bundle for bmc_soft_pipe.
// in_erase exists only when BMC_PUNCTURE_EN is defined.
interface bmc_soft_pipe_if #(
    parameter int SOFT_W = 3,
    parameter int CODE_N = 2,
    parameter int CNT_W  = 10
);
    localparam int SMAX = (1 << SOFT_W) - 1;
    localparam int MW   = $clog2(CODE_N * SMAX + 1);
    localparam int NH   = 1 << CODE_N;

    logic                     in_valid;
    logic                     in_ready;
    logic [CODE_N*SOFT_W-1:0] in_sym;
    logic                     in_last;
`ifdef BMC_PUNCTURE_EN
    logic [CODE_N-1:0]        in_erase;
`endif
    logic                     out_valid;
    logic                     out_ready;
    logic [NH*MW-1:0]         out_bm;
    logic [CNT_W-1:0]         out_idx;
    logic                     out_last;

    modport master (
        output in_valid, in_sym, in_last,
`ifdef BMC_PUNCTURE_EN
        output in_erase,
`endif
        output out_ready,
        input  in_ready, out_valid, out_bm, out_idx, out_last
    );

    modport slave (
        input  in_valid, in_sym, in_last,
`ifdef BMC_PUNCTURE_EN
        input  in_erase,
`endif
        input  out_ready,
        output in_ready, out_valid, out_bm, out_idx, out_last
    );
endinterface

// File: rtl/bmc_soft_pipe.sv
// Soft-decision branch metric unit: 2-stage elastic pipeline, one branch per cycle.
// Optional puncturing (in_erase) is enabled by defining BMC_PUNCTURE_EN.
module bmc_soft_pipe #(
    parameter int SOFT_W = 3,
    parameter int CODE_N = 2,
    parameter int CNT_W  = 10
) (
    input logic           clk,
    input logic           rst_n,
    bmc_soft_pipe_if.slave bus
);
    localparam int SMAX = (1 << SOFT_W) - 1;
    localparam int MW   = $clog2(CODE_N * SMAX + 1);
    localparam int NH   = 1 << CODE_N;
    localparam int DW   = CODE_N * SOFT_W;

    function automatic logic [SOFT_W-1:0] sym_dist(input logic [SOFT_W-1:0] rx,
                                                   input logic b, input logic erased);
        if (erased) return '0;
        return b ? (SOFT_W'(SMAX) - rx) : rx;
    endfunction

    function automatic logic [MW-1:0] hyp_metric(input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                                                 input logic [CODE_N-1:0] hyp);
        logic [MW-1:0] acc;
        acc = '0;
        for (int i = 0; i < CODE_N; i++)
            acc = acc + (hyp[i] ? MW'(d1[i*SOFT_W +: SOFT_W]) : MW'(d0[i*SOFT_W +: SOFT_W]));
        return acc;
    endfunction

    logic              s1_ready, s2_ready, in_xfer;
    logic [CODE_N-1:0] erase;
    logic              s1_valid_q, s1_valid_d;
    logic [DW-1:0]     d0_q, d0_d, d1_q, d1_d;
    logic [CNT_W-1:0]  idx1_q, idx1_d;
    logic              last1_q, last1_d;
    logic              s2_valid_q, s2_valid_d;
    logic [NH*MW-1:0]  bm_q, bm_d;
    logic [CNT_W-1:0]  idx2_q, idx2_d;
    logic              last2_q, last2_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

`ifdef BMC_PUNCTURE_EN
    assign erase = bus.in_erase;
`else
    assign erase = '0;
`endif

    always_comb begin
        s2_ready   = !s2_valid_q || bus.out_ready;
        s1_ready   = !s1_valid_q || s2_ready;
        in_xfer    = bus.in_valid && s1_ready;
        s1_valid_d = s1_valid_q;
        d0_d       = d0_q;
        d1_d       = d1_q;
        idx1_d     = idx1_q;
        last1_d    = last1_q;
        s2_valid_d = s2_valid_q;
        bm_d       = bm_q;
        idx2_d     = idx2_q;
        last2_d    = last2_q;
        cnt_d      = cnt_q;

        // Stage 1: per-symbol distances to both code-bit values
        if (s1_ready) s1_valid_d = bus.in_valid;
        if (in_xfer) begin
            for (int i = 0; i < CODE_N; i++) begin
                d0_d[i*SOFT_W +: SOFT_W] = sym_dist(bus.in_sym[i*SOFT_W +: SOFT_W], 1'b0, erase[i]);
                d1_d[i*SOFT_W +: SOFT_W] = sym_dist(bus.in_sym[i*SOFT_W +: SOFT_W], 1'b1, erase[i]);
            end
            idx1_d  = cnt_q;
            last1_d = bus.in_last;
            cnt_d   = bus.in_last ? '0 : cnt_q + CNT_W'(1);
        end

        // Stage 2: sum distances for every hypothesis
        if (s2_ready) s2_valid_d = s1_valid_q;
        if (s2_ready && s1_valid_q) begin
            for (int h = 0; h < NH; h++)
                bm_d[h*MW +: MW] = hyp_metric(d0_q, d1_q, CODE_N'(h));
            idx2_d  = idx1_q;
            last2_d = last1_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            bm_q       <= '0;
            idx2_q     <= '0;
            last2_q    <= 1'b0;
            cnt_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            bm_q       <= bm_d;
            idx2_q     <= idx2_d;
            last2_q    <= last2_d;
            cnt_q      <= cnt_d;
        end
    end

    // Stage-1 payload is qualified by s1_valid_q, so it needs no reset
    always_ff @(posedge clk) begin
        d0_q    <= d0_d;
        d1_q    <= d1_d;
        idx1_q  <= idx1_d;
        last1_q <= last1_d;
    end

    assign bus.in_ready  = s1_ready;
    assign bus.out_valid = s2_valid_q;
    assign bus.out_bm    = bm_q;
    assign bus.out_idx   = idx2_q;
    assign bus.out_last  = last2_q;
endmodule

// File: tb/tb_bmc_soft_pipe.sv
// Randomized scoreboard bench for bmc_soft_pipe, plus directed metric/latency/stall/reset cases.
module tb_bmc_soft_pipe;
    localparam int SW   = 3;
    localparam int CN   = 2;
    localparam int CW   = 10;
    localparam int SMAX = (1 << SW) - 1;
    localparam int MW   = $clog2(CN * SMAX + 1);
    localparam int NH   = 1 << CN;
    localparam int DW   = CN * SW;

    typedef struct {
        logic [NH*MW-1:0] bm;
        logic [CW-1:0]    idx;
        logic             last;
        int               cyc;
    } exp_t;

    logic clk;
    logic rst_n;
    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   n_in = 0;
    int   model_idx = 0;
    int   wraps = 0;
    bit   lat_chk = 0;
    bit   stall_seen = 0;

    bmc_soft_pipe_if #(.SOFT_W(SW), .CODE_N(CN), .CNT_W(CW)) bus ();
    bmc_soft_pipe_if #(.SOFT_W(1), .CODE_N(2), .CNT_W(CW)) bus_hd ();

    bmc_soft_pipe #(.SOFT_W(SW), .CODE_N(CN), .CNT_W(CW)) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );
    bmc_soft_pipe #(.SOFT_W(1), .CODE_N(2), .CNT_W(CW)) u_dut_hd (
        .clk(clk), .rst_n(rst_n), .bus(bus_hd)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference: metric = sum over symbols of distance to the hypothesised code bit
    function automatic logic [NH*MW-1:0] ref_bm(input logic [DW-1:0] sym, input logic [CN-1:0] er);
        logic [NH*MW-1:0] v;
        int s, rx;
        v = '0;
        for (int h = 0; h < NH; h++) begin
            s = 0;
            for (int i = 0; i < CN; i++) begin
                rx = int'(sym[i*SW +: SW]);
                if (!er[i]) s += (((h >> i) & 1) != 0) ? (SMAX - rx) : rx;
            end
            v[h*MW +: MW] = MW'(s);
        end
        return v;
    endfunction

    task automatic monitor();
        exp_t e;
        logic [CN-1:0] er;
        if (!rst_n) return;
        chk("in_ready", 64'((q.size() < 2) || bus.out_ready), 64'(bus.in_ready));
        if (bus.out_valid) begin
            if (q.size() == 0) chk("out_valid_idle", 64'(bus.out_valid), 64'(0));
            else begin
                e = q[0];
                chk("out_bm", 64'(bus.out_bm), 64'(e.bm));
                chk("out_idx", 64'(bus.out_idx), 64'(e.idx));
                chk("out_last", 64'(bus.out_last), 64'(e.last));
                if (lat_chk) chk("latency", 64'(cyc - e.cyc), 64'(2));
                if (bus.out_ready) void'(q.pop_front());
            end
        end
        if (bus.in_valid && !bus.in_ready) stall_seen = 1;
        if (bus.in_valid && bus.in_ready) begin
`ifdef BMC_PUNCTURE_EN
            er = bus.in_erase;
`else
            er = '0;
`endif
            e.bm   = ref_bm(bus.in_sym, er);
            e.idx  = CW'(model_idx);
            e.last = bus.in_last;
            e.cyc  = cyc;
            q.push_back(e);
            n_in++;
            if (bus.in_last) model_idx = 0;
            else begin
                if (model_idx == (1 << CW) - 1) wraps++;
                model_idx = (model_idx + 1) % (1 << CW);
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle_inputs();
        bus.in_valid = 0; bus.in_sym = '0; bus.in_last = 0; bus.out_ready = 1;
        bus_hd.in_valid = 0; bus_hd.in_sym = '0; bus_hd.in_last = 0; bus_hd.out_ready = 1;
`ifdef BMC_PUNCTURE_EN
        bus.in_erase = '0; bus_hd.in_erase = '0;
`endif
    endtask

    task automatic pulse_reset();
        rst_n = 0;
        #1;
        chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
        chk("rst_in_ready", 64'(bus.in_ready), 64'(1));
        chk("rst_out_bm", 64'(bus.out_bm), 64'(0));
        chk("rst_out_idx", 64'(bus.out_idx), 64'(0));
        chk("rst_out_last", 64'(bus.out_last), 64'(0));
        q.delete();
        model_idx = 0;
        wraps = 0;
        idle_inputs();
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drive_rand(input int valid_pct, input int ready_pct, input int last_div);
        bus.in_valid  = ($urandom_range(99) < valid_pct);
        bus.in_sym    = DW'($urandom);
        bus.in_last   = ($urandom_range(last_div - 1) == 0);
        bus.out_ready = ($urandom_range(99) < ready_pct);
`ifdef BMC_PUNCTURE_EN
        bus.in_erase  = CN'($urandom);
`endif
    endtask

    task automatic drain();
        bus.in_valid = 0; bus.in_last = 0; bus.out_ready = 1;
        for (int k = 0; k < 10 && q.size() > 0; k++) step();
        chk("drain_empty", 64'(q.size()), 64'(0));
    endtask

    task automatic stream8(input int last_at);
        int base;
        pulse_reset();
        base = n_in;
        stall_seen = 0;
        for (int t = 0; t < 40; t++) begin
            bus.in_valid  = (n_in - base) < 8;
            bus.in_sym    = DW'($urandom);
            bus.in_last   = (last_at >= 0) && ((n_in - base) == last_at);
            bus.out_ready = !(t >= 3 && t <= 6);
            step();
            if ((n_in - base) >= 8 && q.size() == 0) break;
        end
        chk("stream_count", 64'(n_in - base), 64'(8));
        chk("stream_ready_drop", 64'(stall_seen), 64'(1));
        drain();
    endtask

    initial begin
        idle_inputs();
        pulse_reset();

        // Hard-decision instance: in_sym=2'b01 gives Hamming metrics 1,0,2,1
        bus_hd.in_valid = 1; bus_hd.in_sym = 2'b01;
        step();
        bus_hd.in_valid = 0;
        chk("hd_ready", 64'(bus_hd.in_ready), 64'(1));
        step();
        chk("hd_valid", 64'(bus_hd.out_valid), 64'(1));
        chk("hd_bm", 64'(bus_hd.out_bm), 64'({2'd1, 2'd2, 2'd0, 2'd1}));
        chk("hd_idx", 64'(bus_hd.out_idx), 64'(0));
        chk("hd_last", 64'(bus_hd.out_last), 64'(0));

        // sym1=7, sym0=0: metrics 7,14,0,7 exactly two cycles after transfer
        bus.in_valid = 1; bus.in_sym = {3'd7, 3'd0}; bus.out_ready = 1;
        step();
        bus.in_valid = 0;
        chk("lat1_valid", 64'(bus.out_valid), 64'(0));
        step();
        chk("lat2_valid", 64'(bus.out_valid), 64'(1));
        chk("bm_7_0", 64'(bus.out_bm), 64'({4'd7, 4'd0, 4'd14, 4'd7}));
        chk("bm_7_0_idx", 64'(bus.out_idx), 64'(0));
        drain();

`ifdef BMC_PUNCTURE_EN
        bus.in_valid = 1; bus.in_sym = {3'd7, 3'd7}; bus.in_erase = 2'b10;
        step();
        bus.in_valid = 0; bus.in_erase = '0;
        step();
        chk("erase_bm", 64'(bus.out_bm), 64'({4'd0, 4'd7, 4'd0, 4'd7}));
        drain();
`endif

        lat_chk = 1;
        for (int k = 0; k < 200; k++) begin drive_rand(70, 100, 8); step(); end
        drain();
        lat_chk = 0;

        for (int k = 0; k < 400; k++) begin
            if (k == 200) pulse_reset();
            else begin drive_rand(75, 60, 6); step(); end
        end
        drain();

        stream8(-1);
        stream8(4);

        pulse_reset();
        for (int k = 0; k < 2060; k++) begin
            bus.in_valid = 1; bus.in_sym = DW'($urandom); bus.out_ready = 1;
            bus.in_last = (model_idx == (1 << CW) - 1) && (wraps == 1);
            step();
        end
        chk("wrap_seen", 64'(wraps >= 1), 64'(1));
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
